nios_system_sysid_checker: RTL and testbench

NIOS_SYSTEM_SYSID_CHECKER -- requirements
Module: nios_system_sysid_checker

---
 rtl/nios_system_sysid_checker.sv | 128 ++++++++++++
 tb/tb_nios_system_sysid_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_sysid_checker.sv
// Reads sysid ID and timestamp over Avalon-MM and compares them to expected values.
// Optional: define SYSID_CHECK_AUTOSTART_EN to run one check right after reset.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480887395,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    FINISH
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_wait;
  logic        r_id_bad;
  logic        w_go;
  logic        w_rd;
  logic        w_ack;
  logic        w_stall;
  logic        w_tmo;
  logic        w_ts_ok;

`ifdef SYSID_CHECK_AUTOSTART_EN
  // High for exactly the first cycle after reset is released.
  logic r_auto;

  always_ff @(posedge clock) begin
    if (reset) r_auto <= 1'b1;
    else       r_auto <= 1'b0;
  end

  assign w_go = start | r_auto;
`else
  assign w_go = start;
`endif

  assign w_rd        = (r_state == RD_ID) || (r_state == RD_TS);
  assign avm_read    = w_rd;
  assign avm_address = (r_state == RD_TS);
  assign busy        = w_rd;
  assign w_ack       = w_rd & ~avm_waitrequest;
  assign w_stall     = w_rd & avm_waitrequest;
  assign w_tmo       = w_stall & ((r_wait + 16'd1) == TMO);
  assign w_ts_ok     = (avm_readdata == EXPECTED_TIMESTAMP);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_go) w_next = RD_ID;
      end
      RD_ID: begin
        if (w_ack)      w_next = RD_TS;
        else if (w_tmo) w_next = FINISH;
      end
      RD_TS: begin
        if (w_ack || w_tmo) w_next = FINISH;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait   <= '0;
      r_id_bad <= 1'b0;
      pass     <= 1'b0;
      err_code <= 2'd0;
      id_value <= '0;
      ts_value <= '0;
    end else if ((r_state == IDLE) && w_go) begin
      r_wait   <= '0;
      r_id_bad <= 1'b0;
      pass     <= 1'b0;
      err_code <= 2'd0;
    end else if (w_ack) begin
      r_wait <= '0;
      if (r_state == RD_ID) begin
        id_value <= avm_readdata;
        r_id_bad <= (avm_readdata != EXPECTED_ID);
      end else begin
        // ID mismatch outranks a timestamp mismatch.
        ts_value <= avm_readdata;
        pass     <= ~r_id_bad & w_ts_ok;
        if (r_id_bad)     err_code <= 2'd1;
        else if (!w_ts_ok) err_code <= 2'd2;
        else              err_code <= 2'd0;
      end
    end else if (w_tmo) begin
      r_wait   <= '0;
      pass     <= 1'b0;
      err_code <= 2'd3;
    end else if (w_stall) begin
      r_wait <= r_wait + 16'd1;
    end
  end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Directed bench for nios_system_sysid_checker with a stallable sysid slave model.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] TS = 32'd1480887395;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int total = 0;
  int bad = 0;

  logic [31:0] rd_id = 32'd0;
  logic [31:0] rd_ts = TS;
  int stall_id = 0;
  int stall_ts = 0;
  int scnt = 0;

  int stalls = 0;
  int stab_bad = 0;
  int reads = 0;
  int dones = 0;
  logic prev_st = 1'b0;
  logic prev_addr = 1'b0;

  always #5 clock = ~clock;

  nios_system_sysid_checker #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_code(err_code),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  assign avm_waitrequest = avm_read &&
    (scnt < (avm_address ? stall_ts : stall_id));
  assign avm_readdata = avm_address ? rd_ts : rd_id;

  always @(posedge clock) begin
    if (avm_read && avm_waitrequest) scnt <= scnt + 1;
    else scnt <= 0;
  end

  always @(posedge clock) begin
    if (prev_st && busy && (!avm_read || avm_address != prev_addr))
      stab_bad = stab_bad + 1;
    if (avm_read && avm_waitrequest) stalls = stalls + 1;
    if (avm_read) reads = reads + 1;
    if (done) dones = dones + 1;
    prev_st = avm_read && avm_waitrequest;
    prev_addr = avm_address;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    int          sid;
    int          sts;
    logic [1:0]  err;
    logic        ps;
    int          lat;
    logic        cv;
  } vec_t;

  vec_t v[9];

  task automatic run_vec(input int k, input vec_t t);
    int lat;
    int s0;
    int b0;
    int es;
    rd_id = t.id;
    rd_ts = t.ts;
    stall_id = t.sid;
    stall_ts = t.sts;
    es = (t.sid < 4) ? t.sid + ((t.sts < 4) ? t.sts : 4) : 4;
    s0 = stalls;
    b0 = stab_bad;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    chk($sformatf("v%0d_lat", k), lat, t.lat);
    chk($sformatf("v%0d_err", k), {30'd0, err_code}, {30'd0, t.err});
    chk($sformatf("v%0d_pass", k), {31'd0, pass}, {31'd0, t.ps});
    chk($sformatf("v%0d_busy", k), {31'd0, busy}, 32'd0);
    if (t.cv) begin
      chk($sformatf("v%0d_id", k), id_value, t.id);
      chk($sformatf("v%0d_ts", k), ts_value, t.ts);
    end
    chk($sformatf("v%0d_stalls", k), stalls - s0, es);
    chk($sformatf("v%0d_stable", k), stab_bad - b0, 0);
    @(negedge clock);
    chk($sformatf("v%0d_done1", k), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_hold", k), {31'd0, pass}, {31'd0, t.ps});
  endtask

  initial begin
    int k;
    int d0;
    int r0;
    int exp_d;
    v[0] = '{32'd0, TS, 0, 0, 2'd0, 1'b1, 3, 1'b1};
    v[1] = '{32'd5, TS, 0, 0, 2'd1, 1'b0, 3, 1'b1};
    v[2] = '{32'd0, TS ^ 32'd1, 0, 0, 2'd2, 1'b0, 3, 1'b1};
    v[3] = '{32'd5, 32'd0, 0, 0, 2'd1, 1'b0, 3, 1'b1};
    v[4] = '{32'd0, TS, 3, 3, 2'd0, 1'b1, 9, 1'b1};
    v[5] = '{32'd0, TS, 255, 0, 2'd3, 1'b0, 5, 1'b0};
    v[6] = '{32'd0, TS, 0, 255, 2'd3, 1'b0, 6, 1'b0};
    v[7] = '{32'd5, TS, 0, 255, 2'd3, 1'b0, 6, 1'b0};
    v[8] = '{32'd0, TS, 2, 1, 2'd0, 1'b1, 6, 1'b1};

    repeat (3) @(negedge clock);
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_addr", {31'd0, avm_address}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err", {30'd0, err_code}, 32'd0);
    chk("rst_id", id_value, 32'd0);
    chk("rst_ts", ts_value, 32'd0);

    r0 = reads;
    d0 = dones;
    reset = 1'b0;
    repeat (8) @(negedge clock);
`ifdef SYSID_CHECK_AUTOSTART_EN
    chk("auto_reads", reads - r0, 2);
    chk("auto_done", dones - d0, 1);
    chk("auto_pass", {31'd0, pass}, 32'd1);
`else
    chk("auto_reads", reads - r0, 0);
    chk("auto_done", dones - d0, 0);
`endif

    for (int i = 0; i < 9; i++) run_vec(i, v[i]);

    // Second start while busy must not extend or repeat the run.
    rd_id = 32'd0;
    rd_ts = TS;
    stall_id = 0;
    stall_ts = 0;
    d0 = dones;
    start = 1'b1;
    @(negedge clock);
    k = 1;
    @(negedge clock);
    start = 1'b0;
    k++;
    while (!done && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("ign_lat", k, 3);
    repeat (5) @(negedge clock);
    chk("ign_dones", dones - d0, 1);

    // Reset wins over start in the same cycle.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    chk("prio_busy", {31'd0, busy}, 32'd0);
    chk("prio_pass", {31'd0, pass}, 32'd0);
    repeat (10) @(negedge clock);

    // Reset during RD_TS discards the sequence.
    stall_ts = 3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!avm_address && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("mid_in_ts", {31'd0, avm_address}, 32'd1);
    d0 = dones;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_read", {31'd0, avm_read}, 32'd0);
    chk("mid_id", id_value, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clock);
`ifdef SYSID_CHECK_AUTOSTART_EN
    exp_d = 1;
`else
    exp_d = 0;
`endif
    chk("mid_nodone", dones - d0, exp_d);
    run_vec(9, v[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
